// File: rtl/omsp_spm_cmd_seq.sv
// Sequencer for Sancus SPM protect/unprotect/verify commands: issues control-array
// strobes, checks the violation flag and streams the derived key into the array.
module omsp_spm_cmd_seq #(
  parameter int unsigned KEY_IDX_SIZE = 3,
  parameter int unsigned KD_TIMEOUT   = 255
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic                    violation,
  output logic                    update_spm,
  output logic                    enable_spm,
  output logic                    disable_spm,
  output logic                    verify_spm,
  output logic                    kd_start,
  input  logic                    kd_valid,
  input  logic [15:0]             kd_word,
  output logic                    kd_ready,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              status
);

  typedef enum logic [2:0] {IDLE, STROBE, CHECK, KD_START, KD_WAIT, DONE} state_t;

  localparam logic [1:0] OP_PROT   = 2'b00;
  localparam logic [1:0] OP_UNPROT = 2'b01;
  localparam logic [1:0] OP_VERIFY = 2'b10;
  localparam logic [1:0] OP_ILL    = 2'b11;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_VIOL = 2'b01;
  localparam logic [1:0] ST_ILL  = 2'b10;
  localparam logic [1:0] ST_TO   = 2'b11;

  localparam logic [KEY_IDX_SIZE:0] LAST_WORD = {1'b0, {KEY_IDX_SIZE{1'b1}}};
  localparam logic [31:0]           TO_LIMIT  = 32'(KD_TIMEOUT);
  localparam bit                    TO_EN     = (KD_TIMEOUT != 0);

  state_t                state;
  logic [1:0]            op;
  logic [KEY_IDX_SIZE:0] word_cnt;
  logic [15:0]           to_cnt;
  logic [15:0]           to_cnt_inc;

  assign to_cnt_inc = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;

  // Strobes, kd_start and done are registered one-cycle pulses set on the
  // transition into the state that owns them.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state       <= IDLE;
      op          <= OP_PROT;
      update_spm  <= 1'b0;
      enable_spm  <= 1'b0;
      disable_spm <= 1'b0;
      verify_spm  <= 1'b0;
      kd_start    <= 1'b0;
      done        <= 1'b0;
      status      <= ST_OK;
      word_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      update_spm  <= 1'b0;
      enable_spm  <= 1'b0;
      disable_spm <= 1'b0;
      verify_spm  <= 1'b0;
      kd_start    <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op <= cmd_op;
            if (cmd_op == OP_ILL) begin
              state  <= DONE;
              status <= ST_ILL;
              done   <= 1'b1;
            end else begin
              state       <= STROBE;
              status      <= ST_OK;
              update_spm  <= (cmd_op == OP_PROT) || (cmd_op == OP_UNPROT);
              enable_spm  <= (cmd_op == OP_PROT);
              disable_spm <= (cmd_op == OP_UNPROT);
              verify_spm  <= (cmd_op == OP_VERIFY);
            end
          end
        end
        STROBE: state <= CHECK;
        CHECK: begin
          if (violation) begin
            state  <= DONE;
            status <= ST_VIOL;
            done   <= 1'b1;
          end else if (op == OP_PROT) begin
            state    <= KD_START;
            kd_start <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        KD_START: begin
          state    <= KD_WAIT;
          word_cnt <= '0;
          to_cnt   <= '0;
        end
        KD_WAIT: begin
          // A word arriving in the expiry cycle takes priority over the timeout.
          if (kd_valid) begin
            word_cnt <= word_cnt + 1'b1;
            to_cnt   <= '0;
            if (word_cnt == LAST_WORD) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt_inc;
            if (TO_EN && (32'(to_cnt_inc) == TO_LIMIT)) begin
              state  <= DONE;
              status <= ST_TO;
              done   <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign kd_ready  = (state == KD_WAIT);
  assign write_key = kd_ready & kd_valid;
  assign key_in    = write_key ? kd_word : 16'h0000;
  assign key_idx   = kd_ready ? word_cnt[KEY_IDX_SIZE-1:0] : '0;

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Bench for omsp_spm_cmd_seq: directed and random commands against a transaction-level
// timing model that predicts every output cycle by cycle from the command and word schedule.
module tb_omsp_spm_cmd_seq;

  localparam int TO = 4;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic        violation;
  logic        update_spm, enable_spm, disable_spm, verify_spm;
  logic        kd_start, kd_valid, kd_ready, write_key;
  logic [15:0] kd_word, key_in;
  logic [2:0]  key_idx;
  logic        busy, done;
  logic [1:0]  status;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0]  prev_status = 2'b00;
  int          gap[8];
  logic [15:0] wd[8];

  omsp_spm_cmd_seq #(.KEY_IDX_SIZE(3), .KD_TIMEOUT(TO)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .violation(violation), .update_spm(update_spm),
    .enable_spm(enable_spm), .disable_spm(disable_spm), .verify_spm(verify_spm),
    .kd_start(kd_start), .kd_valid(kd_valid), .kd_word(kd_word), .kd_ready(kd_ready),
    .write_key(write_key), .key_in(key_in), .key_idx(key_idx), .busy(busy),
    .done(done), .status(status)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string where);
    chk({where, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({where, " busy"},      32'(busy),      32'd0);
    chk({where, " done"},      32'(done),      32'd0);
    chk({where, " strobes"},   32'({update_spm, enable_spm, disable_spm, verify_spm}), 32'd0);
    chk({where, " kd_start"},  32'(kd_start),  32'd0);
    chk({where, " kd_ready"},  32'(kd_ready),  32'd0);
    chk({where, " write_key"}, 32'(write_key), 32'd0);
    chk({where, " key_in"},    32'(key_in),    32'd0);
    chk({where, " key_idx"},   32'(key_idx),   32'd0);
    chk({where, " status"},    32'(status),    32'(prev_status));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      violation = 1'($urandom_range(0, 1));
      kd_valid  = 1'($urandom_range(0, 1));
      kd_word   = 16'($urandom);
      #1;
      check_idle("idle");
    end
  endtask

  // Cycle k=0 is the accept cycle; d is the predicted DONE cycle. Key words are
  // placed from gap[]: a run of TO or more silent cycles expires the key wait.
  task automatic run_cmd(input logic [1:0] op, input logic viol);
    int          d, cur, t, nw;
    logic [1:0]  fst;
    logic        prot, hold_done;
    logic        vld[64];
    logic [15:0] wv[64];
    int          idx_at[64];
    logic        e_kdr, e_wk;
    logic [1:0]  e_st;
    for (int k = 0; k < 64; k++) begin
      vld[k] = 1'b0; wv[k] = 16'h0; idx_at[k] = 0;
    end
    prot = (op == 2'b00) && !viol;
    d = -1; fst = 2'b00;
    if (op == 2'b11) begin
      d = 1; fst = 2'b10;
    end else if (!prot) begin
      d = 3; fst = viol ? 2'b01 : 2'b00;
    end else begin
      cur = 4; nw = 0;
      for (int i = 0; i < 8; i++) begin
        if (gap[i] >= TO) begin
          d = cur + TO; fst = 2'b11;
          break;
        end
        t = cur + gap[i];
        for (int k = cur; k <= t; k++) idx_at[k] = nw;
        vld[t] = 1'b1; wv[t] = wd[i];
        nw++; cur = t + 1;
      end
      if (d < 0) d = cur;
      for (int k = cur; k < d; k++) idx_at[k] = nw;
    end
    for (int k = 0; k <= d; k++)
      if (!(prot && k >= 4 && k < d)) begin
        vld[k] = 1'($urandom_range(0, 1)); wv[k] = 16'($urandom);
      end
    hold_done = 1'($urandom_range(0, 1));

    for (int k = 0; k <= d; k++) begin
      @(negedge mclk);
      cmd_valid = (k < d) || (k == d && hold_done);
      cmd_op    = op;
      violation = (k == 2) ? viol : 1'($urandom_range(0, 1));
      kd_valid  = vld[k];
      kd_word   = wv[k];
      #1;
      e_kdr = prot && k >= 4 && k < d;
      e_wk  = e_kdr && vld[k];
      e_st  = (k == 0) ? prev_status : (op == 2'b11) ? 2'b10 : (k == d) ? fst : 2'b00;
      chk("cmd_ready",   32'(cmd_ready),   32'(k == 0));
      chk("busy",        32'(busy),        32'(k > 0));
      chk("done",        32'(done),        32'(k == d));
      chk("update_spm",  32'(update_spm),  32'(k == 1 && (op == 2'b00 || op == 2'b01)));
      chk("enable_spm",  32'(enable_spm),  32'(k == 1 && op == 2'b00));
      chk("disable_spm", 32'(disable_spm), 32'(k == 1 && op == 2'b01));
      chk("verify_spm",  32'(verify_spm),  32'(k == 1 && op == 2'b10));
      chk("kd_start",    32'(kd_start),    32'(prot && k == 3));
      chk("kd_ready",    32'(kd_ready),    32'(e_kdr));
      chk("write_key",   32'(write_key),   32'(e_wk));
      chk("key_in",      32'(key_in),      e_wk ? 32'(wv[k]) : 32'd0);
      chk("key_idx",     32'(key_idx),     e_kdr ? 32'(idx_at[k]) : 32'd0);
      chk("status",      32'(status),      32'(e_st));
    end
    prev_status = fst;
  endtask

  initial begin
    puc_rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; violation = 1'b0;
    kd_valid = 1'b1; kd_word = 16'hBEEF;
    @(negedge mclk); #1;
    check_idle("reset");
    @(negedge mclk);
    puc_rst = 1'b0; kd_valid = 1'b0;
    #1;
    check_idle("post-reset");

    // Protect, key words 0x1111..0x8888 back-to-back
    for (int i = 0; i < 8; i++) begin gap[i] = 0; wd[i] = 16'(16'h1111 * (i + 1)); end
    run_cmd(2'b00, 1'b0);
    idle_cycles(1);
    run_cmd(2'b00, 1'b1);
    run_cmd(2'b01, 1'b0);
    run_cmd(2'b10, 1'b0);
    run_cmd(2'b11, 1'b0);
    idle_cycles(1);
    run_cmd(2'b10, 1'b1);

    // Three words then a stall long enough to expire
    gap[0] = 0; gap[1] = 0; gap[2] = 0; gap[3] = TO + 5;
    run_cmd(2'b00, 1'b0);
    // Word lands exactly on the would-be expiry cycle
    for (int i = 0; i < 8; i++) gap[i] = 0;
    gap[2] = TO - 1;
    run_cmd(2'b00, 1'b0);
    idle_cycles(1);

    // Reset pulsed while streaming key words
    for (int k = 0; k < 6; k++) begin
      @(negedge mclk);
      cmd_valid = (k < 3); cmd_op = 2'b00; violation = 1'b0;
      kd_valid = (k >= 4); kd_word = 16'hA5A5;
    end
    #1;
    chk("pre-reset kd_ready", 32'(kd_ready), 32'd1);
    chk("pre-reset key_idx",  32'(key_idx),  32'd1);
    @(negedge mclk);
    puc_rst = 1'b1; kd_valid = 1'b1;
    #1;
    prev_status = 2'b00;
    check_idle("mid-reset");
    @(negedge mclk);
    puc_rst = 1'b0;
    #1;
    check_idle("after-reset");
    idle_cycles(2);
    for (int i = 0; i < 8; i++) begin gap[i] = 0; wd[i] = 16'($urandom); end
    run_cmd(2'b00, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 5);
      for (int i = 0; i < 8; i++) begin
        gap[i] = ($urandom_range(0, 11) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
        wd[i]  = 16'($urandom);
      end
      run_cmd((r > 3) ? 2'b00 : 2'(r), ($urandom_range(0, 3) == 0));
      idle_cycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
